// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready immediate extractor/extender with illegal-select counting.
// Optional PC-relative target adder enabled by defining IMM_PC_ADD_EN.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [24:0]      ImmIn,
  input  logic [2:0]       ImmSrc,
`ifdef IMM_PC_ADD_EN
  input  logic [XLEN-1:0]  PcIn,
  output logic [XLEN-1:0]  TargetOut,
`endif
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  ImmExt,
  output logic             Illegal,
  output logic [CNT_W-1:0] IllegalCnt
);

  logic              r_s1_valid;
  logic [24:0]       r_s1_imm;
  logic [2:0]        r_s1_src;
  logic              r_s2_valid;
  logic [XLEN-1:0]   r_s2_imm;
  logic              r_s2_ill;
  logic [CNT_W-1:0]  r_cnt;
`ifdef IMM_PC_ADD_EN
  logic [XLEN-1:0]   r_s1_pc;
  logic [XLEN-1:0]   r_s2_tgt;
`endif

  logic              w_s2_load;
  logic              w_in_acc;
  logic              w_sign;
  logic [XLEN-1:0]   w_ext;
  logic              w_ill;

  assign w_s2_load = !r_s2_valid || OutReady;
  assign InReady   = rst_n && !Flush && (!r_s1_valid || w_s2_load);
  assign w_in_acc  = InValid && InReady;
  assign w_sign    = r_s1_imm[24];

  assign OutValid   = r_s2_valid;
  assign ImmExt     = r_s2_imm;
  assign Illegal    = r_s2_ill;
  assign IllegalCnt = r_cnt;
`ifdef IMM_PC_ADD_EN
  assign TargetOut  = r_s2_tgt;
`endif

  // Format decode and sign/zero extension of the S1 immediate.
  always_comb begin
    w_ext = {XLEN{1'b0}};
    w_ill = 1'b0;
    case (r_s1_src)
      3'b000: w_ext = {{(XLEN-12){w_sign}}, r_s1_imm[24:13]};
      3'b001: w_ext = {{(XLEN-12){w_sign}}, r_s1_imm[24:18], r_s1_imm[4:0]};
      3'b101: w_ext = {{(XLEN-13){w_sign}}, r_s1_imm[24], r_s1_imm[0],
                       r_s1_imm[23:18], r_s1_imm[4:1], 1'b0};
      3'b010: w_ext = XLEN'($signed({r_s1_imm[24:5], 12'h000}));
      3'b110: w_ext = {{(XLEN-21){w_sign}}, r_s1_imm[24], r_s1_imm[12:5],
                       r_s1_imm[13], r_s1_imm[23:14], 1'b0};
      3'b011: w_ext = {{(XLEN-5){1'b0}}, r_s1_imm[12:8]};
      3'b100: begin
        // Shift amount is one bit wider on RV64.
        if (XLEN == 64) begin
          w_ext = {{(XLEN-6){1'b0}}, r_s1_imm[18:13]};
        end else begin
          w_ext = {{(XLEN-5){1'b0}}, r_s1_imm[17:13]};
        end
      end
      3'b111: w_ill = 1'b1;
      default: begin
        w_ext = {XLEN{1'b0}};
        w_ill = 1'b1;
      end
    endcase
  end

  // Stage 1: capture the raw instruction fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_imm   <= 25'd0;
      r_s1_src   <= 3'd0;
`ifdef IMM_PC_ADD_EN
      r_s1_pc    <= {XLEN{1'b0}};
`endif
    end else if (Flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_acc) begin
      r_s1_valid <= 1'b1;
      r_s1_imm   <= ImmIn;
      r_s1_src   <= ImmSrc;
`ifdef IMM_PC_ADD_EN
      r_s1_pc    <= PcIn;
`endif
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: registered result plus saturating count of delivered illegal items.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_imm   <= {XLEN{1'b0}};
      r_s2_ill   <= 1'b0;
      r_cnt      <= {CNT_W{1'b0}};
`ifdef IMM_PC_ADD_EN
      r_s2_tgt   <= {XLEN{1'b0}};
`endif
    end else if (Flush) begin
      r_s2_valid <= 1'b0;
    end else begin
      if (r_s2_valid && OutReady && r_s2_ill && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_imm <= w_ext;
          r_s2_ill <= w_ill;
`ifdef IMM_PC_ADD_EN
          r_s2_tgt <= w_ill ? {XLEN{1'b0}} : (r_s1_pc + w_ext);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe: XLEN=32, XLEN=64 and CNT_W=2 instances
// share the same stimulus.
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [24:0] imm_in;
  logic [2:0]  imm_src;
  logic        out_ready;
  logic [31:0] pc32;
  logic [63:0] pc64;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_imm, a_tgt;
  logic [15:0] a_cnt;
  logic        b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_imm, b_tgt;
  logic [15:0] b_cnt;
  logic        c_in_ready, c_out_valid, c_ill;
  logic [31:0] c_imm, c_tgt;
  logic [1:0]  c_cnt;

  int checks = 0;
  int failures = 0;

  logic [24:0] v_imm [10] = '{25'h1FFE001, 25'h1FC001D, 25'h02468A1, 25'h02468A1, 25'h1FC0018,
                              25'h0002000, 25'h1000000, 25'h107E000, 25'h1000000, 25'h1FFFFFF};
  logic [2:0]  v_src [10] = '{3'b000, 3'b101, 3'b010, 3'b011, 3'b001,
                              3'b110, 3'b110, 3'b100, 3'b010, 3'b011};
  logic [31:0] v_e32 [10] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000008, 32'hFFFFFFF8,
                              32'h00000800, 32'hFFF00000, 32'h0000001F, 32'h80000000, 32'h0000001F};
  logic [63:0] v_e64 [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000,
                              64'h0000000000000008, 64'hFFFFFFFFFFFFFFF8, 64'h0000000000000800,
                              64'hFFFFFFFFFFF00000, 64'h000000000000003F, 64'hFFFFFFFF80000000,
                              64'h000000000000001F};

  imm_ext_pipe #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(a_in_ready),
    .ImmIn(imm_in), .ImmSrc(imm_src),
`ifdef IMM_PC_ADD_EN
    .PcIn(pc32), .TargetOut(a_tgt),
`endif
    .OutValid(a_out_valid), .OutReady(out_ready), .ImmExt(a_imm), .Illegal(a_ill),
    .IllegalCnt(a_cnt)
  );

  imm_ext_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(b_in_ready),
    .ImmIn(imm_in), .ImmSrc(imm_src),
`ifdef IMM_PC_ADD_EN
    .PcIn(pc64), .TargetOut(b_tgt),
`endif
    .OutValid(b_out_valid), .OutReady(out_ready), .ImmExt(b_imm), .Illegal(b_ill),
    .IllegalCnt(b_cnt)
  );

  imm_ext_pipe #(.XLEN(32), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(c_in_ready),
    .ImmIn(imm_in), .ImmSrc(imm_src),
`ifdef IMM_PC_ADD_EN
    .PcIn(pc32), .TargetOut(c_tgt),
`endif
    .OutValid(c_out_valid), .OutReady(out_ready), .ImmExt(c_imm), .Illegal(c_ill),
    .IllegalCnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    imm_in = v_imm[0]; imm_src = v_src[0]; pc32 = 32'h100; pc64 = 64'h100;
    tick(); tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b exp=0", a_out_valid); end
    checks++; if (a_imm !== 32'h0) begin failures++; $display("FAIL reset_immext got=%h exp=0", a_imm); end
    checks++; if (a_ill !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", a_ill); end
    checks++; if (a_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL reset_inready got=%b exp=0", a_in_ready); end
    checks++; if (b_imm !== 64'h0) begin failures++; $display("FAIL reset_immext64 got=%h exp=0", b_imm); end
    in_valid = 1'b0; rst_n = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_inready got=%b exp=1", a_in_ready); end
  endtask

  task automatic test_formats();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      imm_in = v_imm[i]; imm_src = v_src[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL fmt%0d_latency got=%b exp=0", i, a_out_valid); end
      tick();
      checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL fmt%0d_outvalid got=%b exp=1", i, a_out_valid); end
      checks++; if (a_imm !== v_e32[i]) begin failures++; $display("FAIL fmt%0d_imm32 got=%h exp=%h", i, a_imm, v_e32[i]); end
      checks++; if (b_imm !== v_e64[i]) begin failures++; $display("FAIL fmt%0d_imm64 got=%h exp=%h", i, b_imm, v_e64[i]); end
      checks++; if (a_ill !== 1'b0) begin failures++; $display("FAIL fmt%0d_illegal got=%b exp=0", i, a_ill); end
`ifdef IMM_PC_ADD_EN
      checks++; if (a_tgt !== v_e32[i] + 32'h100) begin failures++; $display("FAIL fmt%0d_tgt32 got=%h exp=%h", i, a_tgt, v_e32[i] + 32'h100); end
      checks++; if (b_tgt !== v_e64[i] + 64'h100) begin failures++; $display("FAIL fmt%0d_tgt64 got=%h exp=%h", i, b_tgt, v_e64[i] + 64'h100); end
`endif
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    imm_in = v_imm[0]; imm_src = v_src[0]; in_valid = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%b exp=1", a_in_ready); end
    tick();
    imm_in = v_imm[4]; imm_src = v_src[4];
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", a_in_ready); end
    tick();
    imm_in = v_imm[2]; imm_src = v_src[2];
    #1;
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%b exp=0", a_in_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (a_imm !== 32'hFFFFFFFF || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold%0d got=%h/%b exp=ffffffff/1", k, a_imm, a_out_valid); end
      checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready%0d got=%b exp=0", k, a_in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", a_in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (a_imm !== 32'hFFFFFFF8 || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_order1 got=%h/%b exp=fffffff8/1", a_imm, a_out_valid); end
    tick();
    checks++; if (a_imm !== 32'h12345000 || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_order2 got=%h/%b exp=12345000/1", a_imm, a_out_valid); end
    checks++; if (b_imm !== 64'h0000000012345000) begin failures++; $display("FAIL bp_order2_64 got=%h exp=12345000", b_imm); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_illegal();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imm_in = 25'h1ABCDEF; imm_src = 3'b111; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_ill !== 1'b1) begin failures++; $display("FAIL ill%0d_flag got=%b/%b exp=1/1", i, a_out_valid, a_ill); end
      checks++; if (a_imm !== 32'h0) begin failures++; $display("FAIL ill%0d_imm got=%h exp=0", i, a_imm); end
      checks++; if (a_cnt !== 16'(i)) begin failures++; $display("FAIL ill%0d_cnt got=%0d exp=%0d", i, a_cnt, i); end
      checks++; if (c_cnt !== ((i > 3) ? 2'd3 : 2'(i))) begin failures++; $display("FAIL ill%0d_cnt2 got=%0d exp=%0d", i, c_cnt, (i > 3) ? 3 : i); end
`ifdef IMM_PC_ADD_EN
      checks++; if (a_tgt !== 32'h0) begin failures++; $display("FAIL ill%0d_tgt got=%h exp=0", i, a_tgt); end
`endif
    end
    tick();
    checks++; if (a_cnt !== 16'd5) begin failures++; $display("FAIL ill_final_cnt got=%0d exp=5", a_cnt); end
    checks++; if (c_cnt !== 2'd3) begin failures++; $display("FAIL ill_sat_cnt2 got=%0d exp=3", c_cnt); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL ill_drained got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    imm_in = 25'h0000123; imm_src = 3'b111; in_valid = 1'b1;
    tick(); tick();
    flush = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL flush_inready got=%b exp=0", a_in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_outvalid got=%b exp=0", a_out_valid); end
    out_ready = 1'b1;
    tick(); tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", a_out_valid); end
    checks++; if (a_cnt !== 16'd5 || c_cnt !== 2'd3) begin failures++; $display("FAIL flush_cnt got=%0d/%0d exp=5/3", a_cnt, c_cnt); end
    imm_in = v_imm[1]; imm_src = v_src[1]; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL flush_recover got=%b/%h exp=1/fffffffc", a_out_valid, a_imm); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    imm_in = v_imm[0]; imm_src = v_src[0]; in_valid = 1'b1;
    tick(); tick();
    checks++; if (a_imm !== 32'hFFFFFFFF || a_out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%h/%b exp=ffffffff/1", a_imm, a_out_valid); end
    rst_n = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_imm !== 32'h0 || a_ill !== 1'b0) begin failures++; $display("FAIL rmid_out got=%b/%h/%b exp=0/0/0", a_out_valid, a_imm, a_ill); end
    checks++; if (a_cnt !== 16'h0 || c_cnt !== 2'd0) begin failures++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", a_cnt, c_cnt); end
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL rmid_inready got=%b exp=0", a_in_ready); end
`ifdef IMM_PC_ADD_EN
    checks++; if (a_tgt !== 32'h0) begin failures++; $display("FAIL rmid_tgt got=%h exp=0", a_tgt); end
`endif
    in_valid = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rmid_lost got=%b exp=0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
